// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data RAM behind a valid/ready request channel with a
// fixed-latency single-cycle response pulse. Define DMEM_MMIO_EN to add CYCLES/LED registers.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  led_out
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        r_state;
  logic [3:0]    r_latCnt;
  logic [31:0]   r_holdData;
  logic          r_holdErr;
  logic          r_rspValid;
  logic [31:0]   r_rspRdata;
  logic          r_rspErr;
  logic [31:0]   r_mem [DEPTH];

  logic          w_accept;
  logic [AW-1:0] w_wordIdx;
  logic          w_misaligned;
  logic          w_inRange;
  logic          w_err;
  logic [31:0]   w_rdata;
  logic          w_memWrite;

  assign req_ready    = (r_state == IDLE) && !rst;
  assign w_accept     = req_valid && req_ready;
  assign w_wordIdx    = req_addr[AW+1:2];
  assign w_misaligned = (req_addr[1:0] != 2'b00);
  assign w_inRange    = (req_addr[31:AW+2] == '0);
  assign w_memWrite   = w_accept && req_we && !w_misaligned && w_inRange;

`ifdef DMEM_MMIO_EN
  logic [31:0] r_cycles;
  logic [7:0]  r_led;
  logic        w_isCycles;
  logic        w_isLed;

  assign w_isCycles = (req_addr == 32'hFFFF_0000);
  assign w_isLed    = (req_addr == 32'hFFFF_0004);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycles <= '0;
      r_led    <= '0;
    end else begin
      r_cycles <= r_cycles + 32'd1;
      if (w_accept && req_we && w_isLed)
        r_led <= req_wdata[7:0];
    end
  end

  assign led_out = r_led;
`else
  assign led_out = 8'd0;
`endif

  // Decode the request into the response it will eventually produce.
  always_comb begin
    w_err   = 1'b0;
    w_rdata = '0;
    if (w_misaligned) begin
      w_err = 1'b1;
    end else if (w_inRange) begin
      if (!req_we)
        w_rdata = r_mem[w_wordIdx];
`ifdef DMEM_MMIO_EN
    end else if (w_isCycles) begin
      if (req_we)
        w_err = 1'b1;
      else
        w_rdata = r_cycles;
    end else if (w_isLed) begin
      if (!req_we)
        w_rdata = {24'd0, r_led};
`endif
    end else begin
      w_err = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_memWrite)
      r_mem[w_wordIdx] <= req_wdata;
  end

  // The accepting edge counts as the first latency cycle, so WAIT exits when the count reaches 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_latCnt   <= '0;
      r_holdData <= '0;
      r_holdErr  <= 1'b0;
      r_rspValid <= 1'b0;
      r_rspRdata <= '0;
      r_rspErr   <= 1'b0;
    end else begin
      r_rspValid <= 1'b0;
      r_rspRdata <= '0;
      r_rspErr   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_holdData <= w_rdata;
            r_holdErr  <= w_err;
            if (LATENCY == 1) begin
              r_state    <= RESP;
              r_rspValid <= 1'b1;
              r_rspRdata <= w_rdata;
              r_rspErr   <= w_err;
            end else begin
              r_state  <= WAIT;
              r_latCnt <= LAT_INIT;
            end
          end
        end
        WAIT: begin
          r_latCnt <= r_latCnt - 4'd1;
          if (r_latCnt == 4'd1) begin
            r_state    <= RESP;
            r_rspValid <= 1'b1;
            r_rspRdata <= r_holdData;
            r_rspErr   <= r_holdErr;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rspValid;
  assign rsp_rdata = r_rspRdata;
  assign rsp_err   = r_rspErr;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (DEPTH=16, LATENCY=3); expectations follow
// DMEM_MMIO_EN when it is defined for the build.
module tb_dmem_responder;
  localparam int DEPTH   = 16;
  localparam int LATENCY = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  led_out;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expErr;
  } vec_t;

  vec_t vecs[15];

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .led_out   (led_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Issues one request from a negedge and returns at the negedge after the response cycle.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err, output int lat);
    int guard;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    guard     = 0;
    rdata     = '0;
    err       = 1'b0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL readyTimeout: req_ready stayed 0 for %0d cycles, expected 1", guard);
      req_valid = 1'b0;
      lat = -1;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) begin
      checks++;
      failures++;
      $display("[TB] FAIL rspTimeout: rsp_valid 0 after %0d cycles, expected a pulse", lat);
      lat = -1;
      return;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    @(negedge clk);
    checkOutput("rspSinglePulse", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] rdata;
    logic        err;
    logic [31:0] c1;
    logic [31:0] c2;
    int          lat;
    int          nAcc;
    int          nRsp;
    int          badIdle;
    int          accCyc[3];
    int          rspCyc[3];
    logic [31:0] loadAddrs[3];
    logic [31:0] loadExp[3];
    logic        accNow;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0000, 32'h1111_1111, 32'h0,         1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0002, 32'h0,         32'h0,         1'b1};
    vecs[4]  = '{1'b1, 32'h0000_0002, 32'hBAD0_BAD0, 32'h0,         1'b1};
    vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h1111_1111, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_003C, 32'h5A5A_0F0F, 32'h0,         1'b0};
    vecs[7]  = '{1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 32'h0,         1'b1};
    vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h1111_1111, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_003C, 32'h0,         32'h5A5A_0F0F, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_0040, 32'h0,         32'h0,         1'b1};
    vecs[11] = '{1'b1, 32'h1000_0010, 32'h0BAD_CAFE, 32'h0,         1'b1};
    vecs[12] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[13] = '{1'b1, 32'h0000_0007, 32'h7777_7777, 32'h0,         1'b1};
    vecs[14] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};

    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    repeat (3) @(negedge clk);
    checkOutput("resetReady", {31'd0, req_ready}, 32'd0);
    checkOutput("resetRspValid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("resetRdata", rsp_rdata, 32'd0);
    checkOutput("resetErr", {31'd0, rsp_err}, 32'd0);
    checkOutput("resetLed", {24'd0, led_out}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("readyAfterReset", {31'd0, req_ready}, 32'd1);
    @(negedge clk);

    $display("[TB] directed vector table");
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, rdata, err, lat);
      checkOutput($sformatf("vec%0d.rdata", i), rdata, vecs[i].expRdata);
      checkOutput($sformatf("vec%0d.err", i), {31'd0, err}, {31'd0, vecs[i].expErr});
      checkOutput($sformatf("vec%0d.latency", i), 32'(lat), 32'(LATENCY));
    end

    $display("[TB] back-to-back loads with req_valid held");
    loadAddrs[0] = 32'h0000_0010; loadExp[0] = 32'hDEAD_BEEF;
    loadAddrs[1] = 32'h0000_0000; loadExp[1] = 32'h1111_1111;
    loadAddrs[2] = 32'h0000_003C; loadExp[2] = 32'h5A5A_0F0F;
    nAcc = 0;
    nRsp = 0;
    badIdle = 0;
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = loadAddrs[0];
    for (int c = 0; c < 30; c++) begin
      if (rsp_valid) begin
        if (nRsp < 3) begin
          checkOutput($sformatf("b2b%0d.rdata", nRsp), rsp_rdata, loadExp[nRsp]);
          checkOutput($sformatf("b2b%0d.err", nRsp), {31'd0, rsp_err}, 32'd0);
          rspCyc[nRsp] = c;
        end
        nRsp++;
      end else if (rsp_rdata != 32'd0 || rsp_err) begin
        badIdle++;
      end
      accNow = req_valid && req_ready;
      if (accNow) begin
        if (nAcc < 3) accCyc[nAcc] = c;
        nAcc++;
      end
      @(negedge clk);
      if (accNow) begin
        if (nAcc < 3) req_addr = loadAddrs[nAcc];
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    checkOutput("b2bAccepts", 32'(nAcc), 32'd3);
    checkOutput("b2bResponses", 32'(nRsp), 32'd3);
    checkOutput("b2bIdleOutputsZero", 32'(badIdle), 32'd0);
    if (nAcc == 3 && nRsp == 3) begin
      checkOutput("b2bGap01", 32'(accCyc[1] - accCyc[0]), 32'(LATENCY + 1));
      checkOutput("b2bGap12", 32'(accCyc[2] - accCyc[1]), 32'(LATENCY + 1));
      for (int i = 0; i < 3; i++)
        checkOutput($sformatf("b2b%0d.latency", i), 32'(rspCyc[i] - accCyc[i]), 32'(LATENCY));
    end

    $display("[TB] reset during WAIT");
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = 32'h0000_0014;
    req_wdata = 32'h5555_AAAA;
    checkOutput("midRstReadyBefore", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("midRstReadyDuring", {31'd0, req_ready}, 32'd0);
    nRsp = 0;
    @(negedge clk);
    if (rsp_valid) nRsp++;
    checkOutput("midRstReadyHeld", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("midRstReadyAfter", {31'd0, req_ready}, 32'd1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid) nRsp++;
    end
    checkOutput("midRstNoResponse", 32'(nRsp), 32'd0);
    applyStimulus(1'b0, 32'h0000_0014, 32'h0, rdata, err, lat);
    checkOutput("midRstStoreCommitted", rdata, 32'h5555_AAAA);
    checkOutput("midRstLoadErr", {31'd0, err}, 32'd0);

    $display("[TB] memory-mapped registers");
`ifdef DMEM_MMIO_EN
    checkOutput("ledBeforeStore", {24'd0, led_out}, 32'd0);
    applyStimulus(1'b0, 32'hFFFF_0000, 32'h0, c1, err, lat);
    checkOutput("cycles1.err", {31'd0, err}, 32'd0);
    repeat (LATENCY + 1 + 10 - (LATENCY + 1) - (LATENCY + 1)) @(negedge clk);
    applyStimulus(1'b0, 32'hFFFF_0000, 32'h0, c2, err, lat);
    checkOutput("cycles2.err", {31'd0, err}, 32'd0);
    checkOutput("cyclesDelta", c2 - c1, 32'd10);
    applyStimulus(1'b1, 32'hFFFF_0000, 32'h1234_5678, rdata, err, lat);
    checkOutput("cyclesStore.err", {31'd0, err}, 32'd1);
    applyStimulus(1'b1, 32'hFFFF_0004, 32'h0000_01A5, rdata, err, lat);
    checkOutput("ledStore.err", {31'd0, err}, 32'd0);
    checkOutput("ledOut", {24'd0, led_out}, 32'h0000_00A5);
    applyStimulus(1'b0, 32'hFFFF_0004, 32'h0, rdata, err, lat);
    checkOutput("ledLoad.rdata", rdata, 32'h0000_00A5);
    checkOutput("ledLoad.err", {31'd0, err}, 32'd0);
`else
    applyStimulus(1'b0, 32'hFFFF_0000, 32'h0, rdata, err, lat);
    checkOutput("cyclesLoad.err", {31'd0, err}, 32'd1);
    checkOutput("cyclesLoad.rdata", rdata, 32'd0);
    applyStimulus(1'b1, 32'hFFFF_0004, 32'h0000_01A5, rdata, err, lat);
    checkOutput("ledStore.err", {31'd0, err}, 32'd1);
    checkOutput("ledOutTied", {24'd0, led_out}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
